map_table: RTL and testbench
============================

# map_table

Register alias table for the out-of-order pipeline's dispatch stage. It renames architectural sources and destinations to physical registers, and consumes the `PR_new` value popped from the free list. It supplies the displaced mapping (`PR_old_DP`) that the ROB stores and later returns to the free list at retire. It also tracks per-physical-register ready bits for issue, and restores mappings during branch/jump recovery by replaying the ROB walk.

## Interface
Parameters:
- `NUM_AR`, 32, architectural registers.
- `NUM_PR`, 64, physical registers.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset; asynchronous, active-high.
- `rs`, `rt`  in  5 each  source architectural registers from decode.
- `rd`  in  5  destination architectural register.
- `RegDest`  in  1  instruction at dispatch writes `rd`.
- `PR_new`  in  6  physical register popped from the free list this cycle.
- `hazard_stall`  in  1  global stall.
- `recover`  in  1  recovery walk active.
- `recover_rd`  in  5  architectural destination of the ROB entry being undone.
- `PR_old_flush`  in  6  previous mapping stored in that ROB entry.
- `RegDest_ROB`  in  1  that ROB entry wrote a register.
- `wb_en`  in  1  writeback completes this cycle.
- `wb_PR`  in  6  physical register written back.
- `p_rs`, `p_rt`  out  6 each  physical sources.
- `p_rs_v`, `p_rt_v`  out  1 each  source ready.
- `PR_old_DP`  out  6  current mapping of `rd`; sent to the ROB.

## Operation
- State:
  - `map[0:31]` holds 6-bit entries.
  - `rdy[0:63]` holds 1-bit entries.
- Reset (async):
  - `map[i] = i` for i = 0..31. This matches the free list holding PR32–PR63.
  - `rdy[*] = 1`.
- Lookup is combinational from current state, before this edge's update:
  - `p_rs = map[rs]`, `p_rt = map[rt]`, `PR_old_DP = map[rd]`.
  - `p_rs_v = rdy[p_rs] | (wb_en & wb_PR == p_rs)`. `p_rt_v` is computed the same way.
- Dispatch write: `ren = RegDest & ~hazard_stall & ~recover`.
  - When `ren`, on the edge: `map[rd] <= PR_new` and `rdy[PR_new] <= 0`.
- Recovery write: when `recover & RegDest_ROB`, on the edge: `map[recover_rd] <= PR_old_flush`.
  - `rdy` is not modified by recovery.
  - When `recover & ~RegDest_ROB`, the map is unchanged.
  - Recovery ignores `hazard_stall`; the walk always proceeds.
- Writeback: when `wb_en`, on the edge: `rdy[wb_PR] <= 1`.
  - `wb_en` is honoured during stall and recovery.
- Conflicts:
  - Dispatch clear and writeback set on the same PR in one cycle: the clear wins, because the newer allocation dominates.
  - Dispatch and recovery are mutually exclusive, since `recover` suppresses `ren`.
- AR0 has no special handling. Decode deasserts `RegDest` for `rd = 0`.
- During `recover`, lookup outputs are don't-care.

## Timing
- Lookup latency is 0 cycles (combinational). Writes are visible on the cycle after the edge.
- Same-cycle dependence inside one dispatch (`rs == rd`) reads the old mapping. This is correct for single-issue.
- Writeback bypass makes a source ready in the same cycle its producer writes back.
- Recovery walk:
  - One ROB entry is undone per cycle, youngest first.
  - The map is architecturally correct on the cycle after `recover` deasserts.
  - Dispatch may resume that cycle.
- Stall: state holds apart from writeback, and outputs keep tracking the inputs.
- Reset mid-recovery or mid-stall returns to identity map with all ready bits set. Any walk in progress is abandoned.
- Output values after reset:
  - `p_rs = rs`, `p_rt = rt`, `PR_old_DP = rd`.
  - `p_rs_v = p_rt_v = 1`.

## Test plan
- Reset, then `rs=3, rt=5, rd=7`, `RegDest=0` -> `p_rs=3`, `p_rt=5`, `PR_old_DP=7`, both valid bits 1.
- Rename sequence:
  - Dispatch `rd=4, PR_new=32`, then `rd=4, PR_new=33`, with `PR_old_DP` checked at each dispatch cycle -> 4 on the first, 32 on the second.
  - Next cycle `rs=4` -> `p_rs=33`, `p_rs_v=0`.
- Writeback:
  - `wb_en=1, wb_PR=33` with `rs=4` -> `p_rs_v=1` the same cycle (bypass), and `rdy[33]=1` afterwards.
  - Clear-wins check: dispatch `PR_new=40` with `wb_PR=40` in the same cycle -> `rdy[40]=0`.
- Stall: `hazard_stall=1, RegDest=1, rd=9, PR_new=34` for 2 cycles -> `map[9]` stays 9. Release -> `map[9]=34`.
- Recovery:
  - Starting map `{4→33, 9→34}`, walk `(9, 9, 1)`, `(6, 20, 0)`, `(4, 32, 1)`, `(4, 4, 1)` -> `map[9]=9`, `map[6]` unchanged, `map[4]=4`.
  - `RegDest=1` during the walk produces no writes.
- Assert `rst` mid-walk -> identity map and all ready bits set, immediately and without waiting for a clock edge.

Source files
------------

// File: rtl/map_table.sv
// Register alias table: renames arch regs to physical regs at dispatch, tracks
// per-PR ready bits, and restores mappings during the ROB recovery walk.
module map_table #(
  parameter int NUM_AR = 32,
  parameter int NUM_PR = 64,
  localparam int AW = $clog2(NUM_AR),
  localparam int PW = $clog2(NUM_PR)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] rs,
  input  logic [AW-1:0] rt,
  input  logic [AW-1:0] rd,
  input  logic          RegDest,
  input  logic [PW-1:0] PR_new,
  input  logic          hazard_stall,
  input  logic          recover,
  input  logic [AW-1:0] recover_rd,
  input  logic [PW-1:0] PR_old_flush,
  input  logic          RegDest_ROB,
  input  logic          wb_en,
  input  logic [PW-1:0] wb_PR,
  output logic [PW-1:0] p_rs,
  output logic [PW-1:0] p_rt,
  output logic          p_rs_v,
  output logic          p_rt_v,
  output logic [PW-1:0] PR_old_DP
);

  logic [PW-1:0]     map [NUM_AR];
  logic [NUM_PR-1:0] rdy;
  logic [NUM_PR-1:0] rdy_nxt;
  logic              ren;

  assign ren = RegDest & ~hazard_stall & ~recover;

  assign p_rs      = map[rs];
  assign p_rt      = map[rt];
  assign PR_old_DP = map[rd];
  assign p_rs_v    = rdy[p_rs] | (wb_en & (wb_PR == p_rs));
  assign p_rt_v    = rdy[p_rt] | (wb_en & (wb_PR == p_rt));

  // Clear is applied after set so a fresh allocation beats a stale writeback.
  always_comb begin
    rdy_nxt = rdy;
    if (wb_en) rdy_nxt[wb_PR] = 1'b1;
    if (ren)   rdy_nxt[PR_new] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_AR; i++) map[i] <= PW'(i);
      rdy <= '1;
    end else begin
      if (ren)
        map[rd] <= PR_new;
      else if (recover & RegDest_ROB)
        map[recover_rd] <= PR_old_flush;
      rdy <= rdy_nxt;
    end
  end

endmodule

// File: tb/tb_map_table.sv
// Self-checking bench for map_table: directed vector table, recovery/reset
// sequences, then randomized traffic against a behavioural model.
module tb_map_table;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [4:0] rs = '0, rt = '0, rd = '0, recover_rd = '0;
  logic       RegDest = 1'b0, hazard_stall = 1'b0, recover = 1'b0;
  logic       RegDest_ROB = 1'b0, wb_en = 1'b0;
  logic [5:0] PR_new = '0, PR_old_flush = '0, wb_PR = '0;
  logic [5:0] p_rs, p_rt, PR_old_DP;
  logic       p_rs_v, p_rt_v;

  int checks = 0;
  int failures = 0;

  map_table dut (
    .clk(clk), .rst(rst), .rs(rs), .rt(rt), .rd(rd), .RegDest(RegDest),
    .PR_new(PR_new), .hazard_stall(hazard_stall), .recover(recover),
    .recover_rd(recover_rd), .PR_old_flush(PR_old_flush),
    .RegDest_ROB(RegDest_ROB), .wb_en(wb_en), .wb_PR(wb_PR),
    .p_rs(p_rs), .p_rt(p_rt), .p_rs_v(p_rs_v), .p_rt_v(p_rt_v),
    .PR_old_DP(PR_old_DP)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0] rs, rt, rd;
    logic       regdest, stall, wb_en;
    logic [5:0] pr_new, wb_pr;
    logic [5:0] e_prs, e_prt, e_old;
    logic       e_vs, e_vt;
  } vec_t;

  vec_t vecs[12];

  // Behavioural reference state
  int map_m[32];
  bit rdy_m[64];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    RegDest = 0; hazard_stall = 0; recover = 0; RegDest_ROB = 0; wb_en = 0;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) map_m[i] = i;
    for (int i = 0; i < 64; i++) rdy_m[i] = 1;
  endtask

  // Apply one cycle's rules to the model, as seen at the clock edge.
  task automatic model_step();
    bit dispatch;
    dispatch = RegDest && !hazard_stall && !recover;
    if (wb_en) rdy_m[wb_PR] = 1;
    if (dispatch) begin
      map_m[rd] = PR_new;
      rdy_m[PR_new] = 0;
    end else if (recover && RegDest_ROB) begin
      map_m[recover_rd] = PR_old_flush;
    end
  endtask

  function automatic bit ready_m(input int pr);
    return rdy_m[pr] || (wb_en && wb_PR == pr);
  endfunction

  initial begin
    // {rs, rt, rd, regdest, stall, wb_en, pr_new, wb_pr, e_prs, e_prt, e_old, e_vs, e_vt}
    vecs[0]  = '{3, 5, 7, 0, 0, 0,  0,  0,  3,  5,  7, 1, 1};
    vecs[1]  = '{4, 4, 4, 1, 0, 0, 32,  0,  4,  4,  4, 1, 1};
    vecs[2]  = '{4, 0, 4, 1, 0, 0, 33,  0, 32,  0, 32, 0, 1};
    vecs[3]  = '{4, 4, 4, 0, 0, 0,  0,  0, 33, 33, 33, 0, 0};
    vecs[4]  = '{4, 4, 4, 0, 0, 1,  0, 33, 33, 33, 33, 1, 1};
    vecs[5]  = '{4, 5, 7, 0, 0, 0,  0,  0, 33,  5,  7, 1, 1};
    vecs[6]  = '{5, 6, 5, 1, 0, 1, 40, 40,  5,  6,  5, 1, 1};
    vecs[7]  = '{5, 5, 5, 0, 0, 0,  0,  0, 40, 40, 40, 0, 0};
    vecs[8]  = '{9, 4, 9, 1, 1, 0, 34,  0,  9, 33,  9, 1, 1};
    vecs[9]  = '{9, 4, 9, 1, 1, 0, 34,  0,  9, 33,  9, 1, 1};
    vecs[10] = '{9, 4, 9, 1, 0, 0, 34,  0,  9, 33,  9, 1, 1};
    vecs[11] = '{9, 9, 9, 0, 0, 0,  0,  0, 34, 34, 34, 0, 0};

    #12 rst = 0;
    next_cycle();

    for (int i = 0; i < 12; i++) begin
      rs = vecs[i].rs; rt = vecs[i].rt; rd = vecs[i].rd;
      RegDest = vecs[i].regdest; hazard_stall = vecs[i].stall;
      PR_new = vecs[i].pr_new; wb_en = vecs[i].wb_en; wb_PR = vecs[i].wb_pr;
      #2;
      chk($sformatf("vec%0d p_rs", i), p_rs, vecs[i].e_prs);
      chk($sformatf("vec%0d p_rt", i), p_rt, vecs[i].e_prt);
      chk($sformatf("vec%0d PR_old_DP", i), PR_old_DP, vecs[i].e_old);
      chk($sformatf("vec%0d p_rs_v", i), p_rs_v, vecs[i].e_vs);
      chk($sformatf("vec%0d p_rt_v", i), p_rt_v, vecs[i].e_vt);
      next_cycle();
    end
    idle();

    // Recovery walk with a dispatch attempt held high the whole time.
    RegDest = 1; rd = 10; PR_new = 50; recover = 1;
    recover_rd = 9; PR_old_flush = 9;  RegDest_ROB = 1; next_cycle();
    recover_rd = 6; PR_old_flush = 20; RegDest_ROB = 0; next_cycle();
    recover_rd = 4; PR_old_flush = 32; RegDest_ROB = 1; next_cycle();
    recover_rd = 4; PR_old_flush = 4;  RegDest_ROB = 1; next_cycle();
    idle();
    rs = 9; rt = 6; rd = 4; #2;
    chk("recov map9", p_rs, 9);
    chk("recov map6", p_rt, 6);
    chk("recov map4", PR_old_DP, 4);
    chk("recov map9 ready", p_rs_v, 1);
    rs = 10; rt = 5; rd = 10; #1;
    chk("recov no dispatch map10", p_rs, 10);
    chk("recov map5 kept", p_rt, 40);
    next_cycle();

    // Dispatch resumes straight after the walk; then reset mid-walk.
    RegDest = 1; rd = 4; PR_new = 45; next_cycle();
    RegDest = 0; rs = 4; #1;
    chk("post-recov dispatch map4", p_rs, 45);
    chk("post-recov dispatch rdy45", p_rs_v, 0);
    next_cycle();
    recover = 1; RegDest_ROB = 1; recover_rd = 7; PR_old_flush = 50; next_cycle();
    rst = 1; rs = 4; rt = 7; rd = 5; #1;
    chk("async rst p_rs", p_rs, 4);
    chk("async rst p_rs_v", p_rs_v, 1);
    chk("async rst p_rt", p_rt, 7);
    chk("async rst PR_old_DP", PR_old_DP, 5);
    next_cycle();
    idle();
    rst = 0;
    model_reset();
    next_cycle();

    // Randomized traffic against the reference model.
    for (int n = 0; n < 400; n++) begin
      rs = 5'($urandom_range(31)); rt = 5'($urandom_range(31)); rd = 5'($urandom_range(31));
      RegDest = 1'($urandom_range(1));
      PR_new = 6'($urandom_range(63));
      hazard_stall = ($urandom_range(9) == 0);
      recover = ($urandom_range(7) == 0);
      recover_rd = 5'($urandom_range(31));
      PR_old_flush = 6'($urandom_range(63));
      RegDest_ROB = 1'($urandom_range(1));
      wb_en = 1'($urandom_range(1));
      // Bias writebacks toward live mappings so the bypass path is hit.
      wb_PR = ($urandom_range(1) == 0) ? 6'(map_m[rs]) : 6'($urandom_range(63));
      #2;
      if (!recover) begin
        chk("rand p_rs", p_rs, map_m[rs]);
        chk("rand p_rt", p_rt, map_m[rt]);
        chk("rand PR_old_DP", PR_old_DP, map_m[rd]);
        chk("rand p_rs_v", p_rs_v, ready_m(map_m[rs]));
        chk("rand p_rt_v", p_rt_v, ready_m(map_m[rt]));
      end
      model_step();
      next_cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
